// File: rtl/regpair_bank_incdec.sv
// Register-pair file with byte read/write, address latch, two-cycle
// increment/decrement write-back, one-edge pair exchange and wrap pulse.
module regpair_bank_incdec #(
    parameter int DW     = 8,
    parameter int NPAIRS = 6,
    parameter int SELW   = $clog2(NPAIRS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                op_valid,
    output logic                op_ready,
    input  logic [2:0]          op,
    input  logic [SELW-1:0]     sel,
    input  logic [SELW-1:0]     src_sel,
    input  logic [DW-1:0]       data_in,
    output logic [DW-1:0]       data_out,
    output logic                data_oe,
    output logic [2*DW-1:0]     address,
    output logic                wrap
);

    localparam int PW = 2 * DW;

    localparam logic [2:0] OP_WR_HI = 3'd0;
    localparam logic [2:0] OP_WR_LO = 3'd1;
    localparam logic [2:0] OP_RD_HI = 3'd2;
    localparam logic [2:0] OP_RD_LO = 3'd3;
    localparam logic [2:0] OP_INC   = 3'd4;
    localparam logic [2:0] OP_DEC   = 3'd5;
    localparam logic [2:0] OP_XCHG  = 3'd6;
    localparam logic [2:0] OP_LATCH = 3'd7;

    typedef enum logic {IDLE = 1'b0, WB = 1'b1} state_t;

    state_t          state_reg, state_next;
    logic [PW-1:0]   pair_reg  [NPAIRS];
    logic [PW-1:0]   pair_next [NPAIRS];
    logic [PW-1:0]   sel_pair, src_pair;
    logic            sel_ok, src_ok;
    logic            accept, start_wb;
    logic [PW-1:0]   latch_reg;
    logic [SELW-1:0] idx_reg;
    logic            dec_reg;
    logic [PW-1:0]   wb_value;
    logic            wrap_cond;
    logic [DW-1:0]   data_out_reg;
    logic            data_oe_reg;
    logic [PW-1:0]   address_reg;
    logic            wrap_reg;

    // Out-of-range selects yield a zero read value and a cleared ok flag.
    always_comb begin
        sel_pair = '0;
        src_pair = '0;
        sel_ok   = 1'b0;
        src_ok   = 1'b0;
        for (int i = 0; i < NPAIRS; i++) begin
            if (sel == SELW'(i)) begin
                sel_pair = pair_reg[i];
                sel_ok   = 1'b1;
            end
            if (src_sel == SELW'(i)) begin
                src_pair = pair_reg[i];
                src_ok   = 1'b1;
            end
        end
    end

    assign accept    = op_valid && op_ready;
    assign start_wb  = accept && sel_ok && ((op == OP_INC) || (op == OP_DEC));
    assign wb_value  = dec_reg ? (latch_reg - PW'(1)) : (latch_reg + PW'(1));
    assign wrap_cond = dec_reg ? (latch_reg == '0) : (latch_reg == '1);

    // Per-pair next-value logic; WB owns the write port while it is active.
    for (genvar gi = 0; gi < NPAIRS; gi++) begin : g_pair
        localparam logic [SELW-1:0] IDX = SELW'(gi);
        logic [PW-1:0] nxt;

        always_comb begin
            nxt = pair_reg[gi];
            if (state_reg == WB) begin
                if (idx_reg == IDX) nxt = wb_value;
            end else if (accept) begin
                case (op)
                    OP_WR_HI: if (sel == IDX) nxt[PW-1:DW] = data_in;
                    OP_WR_LO: if (sel == IDX) nxt[DW-1:0]  = data_in;
                    OP_XCHG: begin
                        if (sel_ok && src_ok) begin
                            if (sel == IDX)          nxt = src_pair;
                            else if (src_sel == IDX) nxt = sel_pair;
                        end
                    end
                    default: ;
                endcase
            end
        end

        assign pair_next[gi] = nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NPAIRS; i++) pair_reg[i] <= '0;
        end else begin
            for (int i = 0; i < NPAIRS; i++) pair_reg[i] <= pair_next[i];
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    // FSM: next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_wb) state_next = WB;
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        op_ready = (state_reg == IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out_reg <= '0;
            data_oe_reg  <= 1'b0;
            address_reg  <= '0;
            wrap_reg     <= 1'b0;
            latch_reg    <= '0;
            idx_reg      <= '0;
            dec_reg      <= 1'b0;
        end else begin
            data_oe_reg <= accept && ((op == OP_RD_HI) || (op == OP_RD_LO));
            if (accept && (op == OP_RD_HI)) data_out_reg <= sel_pair[PW-1:DW];
            if (accept && (op == OP_RD_LO)) data_out_reg <= sel_pair[DW-1:0];
            // Address shows the pre-modify value while the pair is updated.
            if (accept && sel_ok &&
                ((op == OP_INC) || (op == OP_DEC) || (op == OP_LATCH)))
                address_reg <= sel_pair;
            wrap_reg <= (state_reg == WB) && wrap_cond;
            if (start_wb) begin
                latch_reg <= sel_pair;
                idx_reg   <= sel;
                dec_reg   <= (op == OP_DEC);
            end
        end
    end

    assign data_out = data_out_reg;
    assign data_oe  = data_oe_reg;
    assign address  = address_reg;
    assign wrap     = wrap_reg;

endmodule

// File: tb/tb_regpair_bank_incdec.sv
// Directed bench for regpair_bank_incdec: byte access, INC/DEC write-back,
// exchange, async reset during WB and out-of-range selects.
module tb_regpair_bank_incdec;

    localparam logic [2:0] WR_HI = 3'd0;
    localparam logic [2:0] WR_LO = 3'd1;
    localparam logic [2:0] RD_HI = 3'd2;
    localparam logic [2:0] RD_LO = 3'd3;
    localparam logic [2:0] INC   = 3'd4;
    localparam logic [2:0] DEC   = 3'd5;
    localparam logic [2:0] XCHG  = 3'd6;
    localparam logic [2:0] LATCH = 3'd7;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic        op_ready;
    logic [2:0]  op;
    logic [2:0]  sel;
    logic [2:0]  src_sel;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        data_oe;
    logic [15:0] address;
    logic        wrap;

    int tests  = 0;
    int failed = 0;

    regpair_bank_incdec dut (
        .clk      (clk),
        .rst      (rst),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op       (op),
        .sel      (sel),
        .src_sel  (src_sel),
        .data_in  (data_in),
        .data_out (data_out),
        .data_oe  (data_oe),
        .address  (address),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one op for exactly one rising edge; returns 1ns after that edge.
    task automatic issue(input logic [2:0] o, input logic [2:0] s,
                         input logic [2:0] ss, input logic [7:0] d);
        op_valid = 1'b1;
        op       = o;
        sel      = s;
        src_sel  = ss;
        data_in  = d;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
    endtask

    task automatic rd_pair(input logic [2:0] s, input logic [15:0] exp);
        issue(RD_HI, s, 3'd0, 8'h00);
        chk($sformatf("rd_hi[%0d]", s), data_out, exp[15:8]);
        chk($sformatf("oe_hi[%0d]", s), data_oe, 1'b1);
        issue(RD_LO, s, 3'd0, 8'h00);
        chk($sformatf("rd_lo[%0d]", s), data_out, exp[7:0]);
    endtask

    initial begin
        rst      = 1'b0;
        op_valid = 1'b0;
        op       = 3'd0;
        sel      = 3'd0;
        src_sel  = 3'd0;
        data_in  = 8'h00;

        #12;
        chk("rst_op_ready", op_ready, 1'b1);
        chk("rst_data_oe",  data_oe,  1'b0);
        chk("rst_data_out", data_out, 8'h00);
        chk("rst_address",  address,  16'h0000);
        chk("rst_wrap",     wrap,     1'b0);
        #10;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Byte write then back-to-back reads
        issue(WR_HI, 3'd0, 3'd0, 8'h11);
        issue(WR_LO, 3'd0, 3'd0, 8'hAA);
        chk("wr_no_oe", data_oe, 1'b0);
        issue(RD_HI, 3'd0, 3'd0, 8'h00);
        chk("rd_hi_bc", data_out, 8'h11);
        chk("rd_hi_oe", data_oe, 1'b1);
        issue(RD_LO, 3'd0, 3'd0, 8'h00);
        chk("rd_lo_bc", data_out, 8'hAA);
        chk("rd_lo_oe", data_oe, 1'b1);
        @(posedge clk);
        #1;
        chk("oe_drop", data_oe, 1'b0);

        // INC of PC with carry across the byte boundary
        issue(WR_HI, 3'd4, 3'd0, 8'h12);
        issue(WR_LO, 3'd4, 3'd0, 8'hFF);
        issue(INC, 3'd4, 3'd0, 8'h00);
        chk("inc_addr",  address,  16'h12FF);
        chk("inc_busy",  op_ready, 1'b0);
        chk("inc_wrap0", wrap,     1'b0);
        @(posedge clk);
        #1;
        chk("inc_ready", op_ready, 1'b1);
        chk("inc_wrap1", wrap,     1'b0);
        chk("inc_addr_hold", address, 16'h12FF);
        rd_pair(3'd4, 16'h1300);

        // DEC of SP from zero wraps; an op during WB is dropped
        issue(WR_HI, 3'd5, 3'd0, 8'h00);
        issue(WR_LO, 3'd5, 3'd0, 8'h00);
        issue(DEC, 3'd5, 3'd0, 8'h00);
        chk("dec_busy", op_ready, 1'b0);
        chk("dec_addr", address,  16'h0000);
        issue(WR_LO, 3'd5, 3'd0, 8'h33);
        chk("dec_wrap",  wrap,     1'b1);
        chk("dec_ready", op_ready, 1'b1);
        @(posedge clk);
        #1;
        chk("dec_wrap_end", wrap, 1'b0);
        rd_pair(3'd5, 16'hFFFF);

        // Exchange DE/HL, then self-exchange
        issue(WR_HI, 3'd1, 3'd0, 8'h12);
        issue(WR_LO, 3'd1, 3'd0, 8'h34);
        issue(WR_HI, 3'd2, 3'd0, 8'hAB);
        issue(WR_LO, 3'd2, 3'd0, 8'hCD);
        issue(XCHG, 3'd1, 3'd2, 8'h00);
        rd_pair(3'd1, 16'hABCD);
        rd_pair(3'd2, 16'h1234);
        issue(XCHG, 3'd2, 3'd2, 8'h00);
        rd_pair(3'd2, 16'h1234);
        rd_pair(3'd4, 16'h1300);

        // Async reset in the middle of WB
        issue(INC, 3'd0, 3'd0, 8'h00);
        chk("mid_busy", op_ready, 1'b0);
        chk("mid_addr", address, 16'h11AA);
        #2;
        rst = 1'b0;
        #1;
        chk("async_ready", op_ready, 1'b1);
        chk("async_addr",  address,  16'h0000);
        chk("async_wrap",  wrap,     1'b0);
        chk("async_oe",    data_oe,  1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_wrap", wrap, 1'b0);
        chk("post_rst_addr", address, 16'h0000);
        for (int i = 0; i < 6; i++) rd_pair(3'(i), 16'h0000);

        // Out-of-range select
        issue(WR_LO, 3'd1, 3'd0, 8'h5A);
        issue(WR_HI, 3'd7, 3'd0, 8'h55);
        for (int i = 0; i < 6; i++) rd_pair(3'(i), (i == 1) ? 16'h005A : 16'h0000);
        issue(RD_LO, 3'd1, 3'd0, 8'h00);
        chk("pre_oor_rd", data_out, 8'h5A);
        issue(RD_LO, 3'd7, 3'd0, 8'h00);
        chk("oor_rd_data", data_out, 8'h00);
        chk("oor_rd_oe",   data_oe,  1'b1);
        issue(LATCH, 3'd1, 3'd0, 8'h00);
        chk("latch_addr",  address,  16'h005A);
        chk("latch_ready", op_ready, 1'b1);
        issue(INC, 3'd7, 3'd0, 8'h00);
        chk("oor_inc_ready", op_ready, 1'b1);
        chk("oor_inc_addr",  address,  16'h005A);
        issue(LATCH, 3'd7, 3'd0, 8'h00);
        chk("oor_latch_addr", address, 16'h005A);
        issue(XCHG, 3'd1, 3'd7, 8'h00);
        rd_pair(3'd1, 16'h005A);
        @(posedge clk);
        #1;
        chk("final_wrap", wrap, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
